// File: rtl/counter_sample_fifo_if.sv
// counter_sample_fifo_if: 32-bit valid/ready sample stream between the
// counter sampler and the fabric bus bridge.
interface counter_sample_fifo_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/counter_sample_fifo.sv
// counter_sample_fifo: gates the enable of a 20-bit free-running counter,
// captures every incremented value into a first-word-fall-through FIFO and
// streams the samples out as 32-bit words. A run issues a programmed number
// of samples; the enable is throttled so that the FIFO can never overflow.
// Optional: define COUNTER_SAMPLE_SEQ_TAG_EN to store a 12-bit sequence tag
// with each sample and present it on m_data[31:20] (otherwise those bits are 0).
module counter_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int NUM_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 flush,
  input  logic [NUM_W-1:0]     num_samples,
  output logic                 cnt_en,
  input  logic [19:0]          cnt_data,
  counter_sample_fifo_if.master strm,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] OCC_MAX  = (AW+2)'(DEPTH);

`ifdef COUNTER_SAMPLE_SEQ_TAG_EN
  localparam int DW = 32;
`else
  localparam int DW = 20;
`endif

  state_t            state_reg, state_next;
  logic [NUM_W-1:0]  issued_reg, issued_next;
  logic [NUM_W-1:0]  target_reg, target_next;
  logic              en_d_reg;
  logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
  logic [AW:0]       level_reg, level_next;
  logic [DW-1:0]     mem [DEPTH];
  logic [DW-1:0]     head_reg;
  logic [DW-1:0]     wdata;
  logic              start_accept;
  logic              flush_eff;
  logic              push;
  logic              pop;
  logic              room;
  logic [AW+1:0]     occ;

  // A capture is in flight while en_d is high; it is written on this edge.
  assign push      = en_d_reg;
  assign pop       = !empty && strm.m_ready;
  assign flush_eff = (state_reg == IDLE) && flush;

  // Occupancy counts the in-flight capture but gives no credit for a pop in
  // the same cycle, so a granted enable always has a free slot waiting.
  assign occ  = {1'b0, level_reg} + {{(AW+1){1'b0}}, en_d_reg};
  assign room = occ < OCC_MAX;

  assign level = level_reg;
  assign empty = (level_reg == '0);
  assign full  = (level_reg == LVL_FULL);
  assign busy  = (state_reg != IDLE);
  assign strm.m_valid = !empty;

`ifdef COUNTER_SAMPLE_SEQ_TAG_EN
  logic [11:0] tag_reg;

  // Sequence tag: restarts with every accepted run, advances per captured sample.
  always_ff @(posedge clk) begin
    if (!rstn)             tag_reg <= '0;
    else if (start_accept) tag_reg <= '0;
    else if (push)         tag_reg <= tag_reg + 12'd1;
  end

  assign wdata       = {tag_reg, cnt_data};
  assign strm.m_data = head_reg;
`else
  assign wdata       = cnt_data;
  assign strm.m_data = {12'd0, head_reg};
`endif

  // Run control: start/abort handling, enable gating and sample accounting.
  always_comb begin
    state_next   = state_reg;
    issued_next  = issued_reg;
    target_next  = target_reg;
    cnt_en       = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    unique case (state_reg)
      IDLE: begin
        // flush wins over a coincident start
        if (!flush && start && (num_samples != '0)) begin
          start_accept = 1'b1;
          target_next  = num_samples;
          issued_next  = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        cnt_en = !abort && room && (issued_reg < target_reg);
        if (cnt_en) issued_next = issued_reg + 1'b1;
        if (abort || (cnt_en && (issued_next == target_reg))) state_next = WAIT;
      end
      WAIT: begin
        // hold until the last in-flight capture has landed in the FIFO
        if (!en_d_reg) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO pointer and occupancy update; flush only rewinds the bookkeeping.
  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    level_next  = level_reg;
    if (flush_eff) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      level_next  = '0;
    end else begin
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (push && !pop)      level_next = level_reg + 1'b1;
      else if (!push && pop) level_next = level_reg - 1'b1;
    end
  end

  // Control and pointer state registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      issued_reg <= '0;
      target_reg <= '0;
      en_d_reg   <= 1'b0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      issued_reg <= issued_next;
      target_reg <= target_next;
      en_d_reg   <= cnt_en;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      level_reg  <= level_next;
    end
  end

  // Sample storage with a registered read of the next head entry; a write
  // into the slot that becomes the head is forwarded so the stream shows it
  // one cycle after the write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
    if (push && (wr_ptr_reg == rd_ptr_next)) head_reg <= wdata;
    else                                     head_reg <= mem[rd_ptr_next];
  end

endmodule

// File: tb/tb_counter_sample_fifo.sv
// tb_counter_sample_fifo: directed bench for counter_sample_fifo with a
// queue-based reference model checked every cycle on the falling edge.
module tb_counter_sample_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NUM_W = 16;
`ifdef COUNTER_SAMPLE_SEQ_TAG_EN
  localparam bit TAG_ON = 1'b1;
`else
  localparam bit TAG_ON = 1'b0;
`endif
  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_WAIT = 2;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             abort;
  logic             flush;
  logic [NUM_W-1:0] num_samples;
  logic             cnt_en;
  logic [19:0]      cnt_data;
  logic [AW:0]      level;
  logic             full;
  logic             empty;
  logic             busy;
  logic             done;

  // free-running counter environment
  logic [19:0] tb_cnt = 20'd0;
  logic        cnt_load;
  logic [19:0] cnt_load_val;

  counter_sample_fifo_if sif ();

  counter_sample_fifo #(.DEPTH(DEPTH), .AW(AW), .NUM_W(NUM_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .flush       (flush),
    .num_samples (num_samples),
    .cnt_en      (cnt_en),
    .cnt_data    (cnt_data),
    .strm        (sif),
    .level       (level),
    .full        (full),
    .empty       (empty),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cnt_load)    tb_cnt <= cnt_load_val;
    else if (cnt_en) tb_cnt <= tb_cnt + 20'd1;
  end
  assign cnt_data = tb_cnt;

  int errors = 0;
  int checks = 0;

  // reference model
  int          ph = P_IDLE;
  int          issued = 0;
  int          target = 0;
  bit          inflight = 1'b0;
  logic [19:0] inflight_val = 20'd0;
  logic [19:0] mcnt = 20'd0;
  logic [11:0] mtag = 12'd0;
  logic [31:0] q [$];

  // observations
  logic [31:0] got [$];
  int          done_cnt = 0;
  int          en_cycles = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int tag, input logic [19:0] val);
    logic [11:0] t;
    t = TAG_ON ? 12'(tag) : 12'd0;
    return {t, val};
  endfunction

  task automatic compare_loop();
    logic exp_en;
    bit   was_inflight;
    forever begin
      @(negedge clk);
      exp_en = (ph == P_RUN) && !abort && ((q.size() + int'(inflight)) < DEPTH) && (issued < target);
      if (rstn) begin
        chk("cnt_en", 32'(cnt_en), 32'(exp_en));
        chk("m_valid", 32'(sif.m_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("m_data", sif.m_data, q[0]);
        chk("level", 32'(level), 32'(q.size()));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("busy", 32'(busy), 32'(ph != P_IDLE));
        chk("done", 32'(done), 32'((ph == P_WAIT) && !inflight));
        if (sif.m_valid && sif.m_ready) begin
          got.push_back(sif.m_data);
          $display("pop data=%08h level=%0d", sif.m_data, level);
        end
        if (done === 1'b1) done_cnt++;
        if (cnt_en === 1'b1) en_cycles++;
      end
      // counter environment follows the predicted enable
      if (cnt_load)    mcnt = cnt_load_val;
      else if (exp_en) mcnt = mcnt + 20'd1;
      if (!rstn) begin
        ph = P_IDLE; issued = 0; target = 0; inflight = 1'b0; mtag = 12'd0;
        q.delete();
      end else begin
        if (ph == P_IDLE && flush) q.delete();
        else begin
          if (q.size() != 0 && sif.m_ready) void'(q.pop_front());
          if (inflight) begin
            q.push_back(exp_word(int'(mtag), inflight_val));
            mtag = mtag + 12'd1;
          end
        end
        was_inflight = inflight;
        inflight = exp_en;
        if (exp_en) begin
          inflight_val = mcnt;
          issued++;
        end
        case (ph)
          P_IDLE: if (!flush && start && num_samples != 0) begin
            ph = P_RUN; target = int'(num_samples); issued = 0; mtag = 12'd0;
          end
          P_RUN:  if (abort || issued == target) ph = P_WAIT;
          default: if (!was_inflight) ph = P_IDLE;
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [19:0] v);
    cnt_load_val = v;
    cnt_load = 1'b1;
    step();
    cnt_load = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    num_samples = NUM_W'(n);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_obs();
    got.delete();
    done_cnt = 0;
    en_cycles = 0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin step(); n++; end
    chk(nm, 32'(busy), 32'd0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (empty !== 1'b1 && n < 300) begin step(); n++; end
    chk(nm, 32'(empty), 32'd1);
    step();
  endtask

  task automatic stimulus();
    logic [19:0] wrap_vals [4];
    int n;
    wrap_vals[0] = 20'hFFFFF; wrap_vals[1] = 20'h00000;
    wrap_vals[2] = 20'h00001; wrap_vals[3] = 20'h00002;

    step(); step();
    rstn = 1'b1;
    step();

    // basic run of three samples
    sif.m_ready = 1'b1;
    preload(20'd0);
    clear_obs();
    pulse_start(3);
    wait_idle("basic_idle_timeout");
    drain("basic_drain_timeout");
    chk("basic_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) for (int i = 0; i < 3; i++) chk("basic_data", got[i], exp_word(i, 20'(i + 1)));
    chk("basic_done", 32'(done_cnt), 32'd1);
    chk("basic_en_cycles", 32'(en_cycles), 32'd3);
    chk("basic_level", 32'(level), 32'd0);

    // start and flush while busy are ignored
    preload(20'd0);
    clear_obs();
    pulse_start(10);
    step(); step();
    num_samples = 16'd7; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    wait_idle("ign_idle_timeout");
    drain("ign_drain_timeout");
    chk("ign_count", 32'(got.size()), 32'd10);
    chk("ign_en_cycles", 32'(en_cycles), 32'd10);
    if (got.size() == 10) chk("ign_last", got[9], exp_word(9, 20'd10));
    chk("ign_done", 32'(done_cnt), 32'd1);

    // full FIFO backpressure then release
    sif.m_ready = 1'b0;
    preload(20'd0);
    clear_obs();
    pulse_start(20);
    repeat (40) step();
    chk("full_level", 32'(level), 32'd16);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_cnt_en", 32'(cnt_en), 32'd0);
    chk("full_en_cycles", 32'(en_cycles), 32'd16);
    chk("full_head", sif.m_data, exp_word(0, 20'd1));
    sif.m_ready = 1'b1;
    wait_idle("full_idle_timeout");
    drain("full_drain_timeout");
    chk("full_count", 32'(got.size()), 32'd20);
    if (got.size() == 20) for (int i = 0; i < 20; i++) chk("full_data", got[i], exp_word(i, 20'(i + 1)));
    chk("full_done", 32'(done_cnt), 32'd1);

    // abort after five enabled cycles
    preload(20'd0);
    clear_obs();
    pulse_start(100);
    n = 0;
    while (en_cycles < 5 && n < 50) begin step(); n++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    wait_idle("abort_idle_timeout");
    drain("abort_drain_timeout");
    chk("abort_count", 32'(got.size()), 32'd5);
    chk("abort_en_cycles", 32'(en_cycles), 32'd5);
    chk("abort_done", 32'(done_cnt), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    if (got.size() == 5) chk("abort_last", got[4], exp_word(4, 20'd5));

    // counter wrap with sequence tags
    preload(20'hFFFFE);
    clear_obs();
    pulse_start(4);
    wait_idle("wrap_idle_timeout");
    drain("wrap_drain_timeout");
    chk("wrap_count", 32'(got.size()), 32'd4);
    if (got.size() == 4) for (int i = 0; i < 4; i++) chk("wrap_data", got[i], exp_word(i, wrap_vals[i]));

    // flush in IDLE beats a coincident start
    sif.m_ready = 1'b0;
    preload(20'd0);
    clear_obs();
    pulse_start(5);
    wait_idle("flush_idle_timeout");
    step();
    chk("flush_level_before", 32'(level), 32'd5);
    num_samples = 16'd3; flush = 1'b1; start = 1'b1;
    step();
    flush = 1'b0; start = 1'b0;
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(sif.m_valid), 32'd0);

    // reset in the middle of a run
    sif.m_ready = 1'b1;
    preload(20'd0);
    pulse_start(50);
    repeat (5) step();
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst_cnt_en", 32'(cnt_en), 32'd0);
    chk("rst_valid", 32'(sif.m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // short run after reset
    preload(20'd0);
    clear_obs();
    pulse_start(2);
    wait_idle("post_rst_idle_timeout");
    drain("post_rst_drain_timeout");
    chk("post_rst_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) chk("post_rst_first", got[0], exp_word(0, 20'd1));
    step();
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; flush = 1'b0;
    num_samples = '0; sif.m_ready = 1'b0; cnt_load = 1'b0; cnt_load_val = 20'd0;
    fork
      compare_loop();
      stimulus();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
